mem_arbiter_fsm: RTL and testbench
==================================

Name: mem_arbiter_fsm

Overview:
- Shares the single RAM port between the pipeline's instruction-fetch requester and its data-memory requester.
- Sits between the datapath/request logic and the memory (RAM) port.
- A registered FSM grants one requester at a time and holds its address/data stable for the whole access.
- It returns a one-cycle hit pulse with registered load data.
- Data requests have priority; a bounded starvation counter guarantees forward progress of fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
STARVE_MAX, 4, max consecutive data grants while a fetch is pending before fetch is forced (range 1..15)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request (level, held until ihit)
iaddr  in  ADDR_W  instruction address
dREN  in  1  data read request (level)
dWEN  in  1  data write request (level)
daddr  in  ADDR_W  data address
dstore  in  DATA_W  data write value
ihit  out  1  instruction access complete, one-cycle pulse
dhit  out  1  data access complete, one-cycle pulse
iload  out  DATA_W  registered instruction word, valid when ihit
dload  out  DATA_W  registered data read value, valid when dhit after a read
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data, valid with ram_ready
ram_ready  in  1  RAM access complete this cycle
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock, reset: one clock CLK; reset nRST is asynchronous and active-low.
- Reset values:
  - state = IDLE, starve counter = 0.
  - All outputs 0: ihit, dhit, iload, dload, ram*, busy.
  - Latched address, store data and op fields = 0.
  - Reset asserted mid-access aborts the access immediately; no hit is produced.
- States: IDLE, IACC, DACC, RESP.
- IDLE arbitration, evaluated every cycle; the result is registered at the clock edge:
  - Data pending (dREN|dWEN) and not forced → DACC. Latch daddr, dstore, and op (write if dWEN, else read).
  - dREN and dWEN both high → treated as a write; dload unchanged.
  - Else iREN → IACC. Latch iaddr.
  - Forced fetch: iREN && data pending && starve_cnt == STARVE_MAX → IACC.
  - No request → stay in IDLE.
- Starve counter (4 bits, saturating at STARVE_MAX):
  - Increments on a DACC grant when iREN is high.
  - Clears on any IACC grant, and on a DACC grant when iREN is low.
- IACC: ramREN=1, ramWEN=0, ramaddr=latched address.
  - On ram_ready: register ramload into iload, set ihit=1, go to RESP.
- DACC: ramREN=!op_write, ramWEN=op_write, ramaddr=latched address, ramstore=latched store data.
  - On ram_ready: set dhit=1; a read also registers ramload into dload. Go to RESP.
- RESP: exactly one cycle.
  - Hit pulse is visible; all ram* enables are 0; no arbitration, so a request still held during the hit cycle is not re-granted.
  - Next state is IDLE; hits clear.
- Latency:
  - Request seen in IDLE at cycle 0 → ram enables from cycle 1.
  - ram_ready at cycle k ≥ 1 → hit in cycle k+1 → IDLE at k+2. Minimum request-to-hit is 2 cycles.
- ram* outputs are driven from registered state and latched fields only. Input changes during an access do not affect the RAM port.
- A requester that drops its request mid-access does not abort the access; its hit still pulses.
- ram_ready outside IACC/DACC is ignored.
- ihit and dhit are never high together.
- iload and dload hold their value between hits.

Test Plan:
- Reset: nRST=0 mid-DACC with ram_ready pending → all outputs 0 at once; after release with no requests, state stays IDLE and busy=0.
- Single fetch: iREN=1, iaddr=0x40, ram_ready=1 two cycles after grant, ramload=0x8C220004 → ramREN=1 and ramaddr=0x40 for 2 cycles; ihit 1-cycle pulse with iload=0x8C220004; no re-grant during the hit cycle.
- Data write vs fetch conflict: iREN and dWEN (daddr=0x100, dstore=0xDEADBEEF) raised in the same cycle → DACC first with ramWEN=1, ramstore=0xDEADBEEF; dhit; then IACC; then ihit.
- Starvation: iREN held; data requests issued back-to-back, STARVE_MAX=4 → exactly 4 data grants, then a forced fetch grant; counter cleared afterwards.
- Input change mid-access: daddr switched 0x100→0x200 during DACC → ramaddr stays 0x100 until dhit.
- Read data: dREN, daddr=0x80, ramload=0x12345678 → dload=0x12345678 with dhit. A following write leaves dload unchanged.

Source files
------------

// File: rtl/mem_arbiter_fsm.sv
// Single-port RAM arbiter between instruction fetch and data memory.
// Data has priority; a starvation counter forces fetch through.
module mem_arbiter_fsm #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t state, next_state;

  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic              op_write;
  logic              sel_d;

  logic dpend, forced, grant_d, grant_i;

  // Arbitration decision, only meaningful in IDLE
  always_comb begin
    dpend   = dREN | dWEN;
    forced  = iREN & dpend & (starve_cnt == SMAX);
    grant_d = (state == IDLE) & dpend & ~forced;
    grant_i = (state == IDLE) & iREN & ~grant_d;
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      next_state = DACC;
        else if (grant_i) next_state = IACC;
      end
      IACC: if (ram_ready) next_state = RESP;
      DACC: if (ram_ready) next_state = RESP;
      RESP: next_state = IDLE;
    endcase
  end

  // Latched access fields, starvation counter and load registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
      addr_q     <= '0;
      store_q    <= '0;
      op_write   <= 1'b0;
      sel_d      <= 1'b0;
      iload      <= '0;
      dload      <= '0;
    end else begin
      if (grant_d) begin
        addr_q   <= daddr;
        store_q  <= dstore;
        op_write <= dWEN;
        sel_d    <= 1'b1;
        if (!iREN)
          starve_cnt <= '0;
        else if (starve_cnt != SMAX)
          starve_cnt <= starve_cnt + 4'd1;
      end else if (grant_i) begin
        addr_q     <= iaddr;
        op_write   <= 1'b0;
        sel_d      <= 1'b0;
        starve_cnt <= '0;
      end
      if (state == IACC && ram_ready)
        iload <= ramload;
      if (state == DACC && ram_ready && !op_write)
        dload <= ramload;
    end
  end

  // RAM port and hit outputs from registered state only
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE: ;
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
      end
      DACC: begin
        ramREN   = ~op_write;
        ramWEN   = op_write;
        ramaddr  = addr_q;
        ramstore = store_q;
      end
      RESP: begin
        ihit = ~sel_d;
        dhit = sel_d;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Directed bench for mem_arbiter_fsm.
// Inputs change 1ns after the rising edge; outputs checked there.
module tb_mem_arbiter_fsm;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, busy;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter_fsm #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit),
    .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int nd;
  bit got;

  initial begin
    nRST = 1'b0;
    iREN = 0; dREN = 0; dWEN = 0;
    ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_ren", ramREN, 0);
    chk("rst_iload", iload, 0);
    nRST = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // single fetch, ready two cycles after grant
    iREN = 1; iaddr = 32'h40;
    tick();
    chk("f_ren1", ramREN, 1);
    chk("f_addr1", ramaddr, 32'h40);
    chk("f_wen1", ramWEN, 0);
    tick();
    chk("f_ren2", ramREN, 1);
    chk("f_ihit0", ihit, 0);
    ram_ready = 1; ramload = 32'h8C220004;
    tick();
    ram_ready = 0;
    chk("f_ihit", ihit, 1);
    chk("f_iload", iload, 32'h8C220004);
    chk("f_ren_resp", ramREN, 0);
    chk("f_dhit", dhit, 0);
    tick();
    chk("f_ihit_off", ihit, 0);
    chk("f_nogrant", busy, 0);
    iREN = 0;
    tick();
    chk("f_idle", busy, 0);

    // write vs fetch conflict plus mid-access addr change
    iREN = 1; iaddr = 32'h44;
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    tick();
    chk("c_wen", ramWEN, 1);
    chk("c_ren", ramREN, 0);
    chk("c_addr", ramaddr, 32'h100);
    chk("c_store", ramstore, 32'hDEADBEEF);
    daddr = 32'h200; dstore = 32'h0;
    tick();
    chk("c_addr_hold", ramaddr, 32'h100);
    chk("c_store_hold", ramstore, 32'hDEADBEEF);
    ram_ready = 1; dWEN = 0;
    tick();
    ram_ready = 0;
    chk("c_dhit", dhit, 1);
    chk("c_ihit0", ihit, 0);
    tick();
    chk("c_idle", busy, 0);
    tick();
    chk("c_iacc", ramREN, 1);
    chk("c_iaddr", ramaddr, 32'h44);
    ram_ready = 1; ramload = 32'h11;
    tick();
    ram_ready = 0; iREN = 0;
    chk("c_ihit", ihit, 1);
    chk("c_iload", iload, 32'h11);
    tick();

    // data read
    dREN = 1; daddr = 32'h80;
    ram_ready = 1; ramload = 32'h12345678;
    tick();
    dREN = 0;
    chk("r_ren", ramREN, 1);
    chk("r_addr", ramaddr, 32'h80);
    tick();
    chk("r_dhit", dhit, 1);
    chk("r_dload", dload, 32'h12345678);
    ram_ready = 0;
    tick();

    // write with both enables: treated as write
    dREN = 1; dWEN = 1; daddr = 32'h84;
    dstore = 32'h5; ramload = 32'hFFFF;
    ram_ready = 1;
    tick();
    dREN = 0; dWEN = 0;
    chk("w_wen", ramWEN, 1);
    chk("w_ren", ramREN, 0);
    tick();
    chk("w_dhit", dhit, 1);
    chk("w_dload", dload, 32'h12345678);
    ram_ready = 0;
    tick();

    // starvation: two rounds of 4 data grants then fetch
    iREN = 1; iaddr = 32'h300;
    dREN = 1; daddr = 32'h400;
    ram_ready = 1; ramload = 32'hA5;
    for (int r = 0; r < 2; r++) begin
      nd = 0;
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        tick();
        chk("s_excl", ihit & dhit, 0);
        if (dhit) nd++;
        if (ihit) got = 1;
      end
      chk("s_ndata", nd, 4);
      chk("s_fetch", got, 1);
    end
    iREN = 0; dREN = 0; ram_ready = 0;
    tick();
    tick();
    chk("s_idle", busy, 0);

    // reset mid-DACC with ready pending
    dREN = 1; daddr = 32'h88;
    tick();
    chk("x_dacc", ramREN, 1);
    ram_ready = 1;
    #1 nRST = 1'b0;
    #1;
    chk("x_busy", busy, 0);
    chk("x_ren", ramREN, 0);
    chk("x_addr", ramaddr, 0);
    chk("x_dload", dload, 0);
    dREN = 0; ram_ready = 0;
    tick();
    nRST = 1'b1;
    tick();
    chk("x_dhit", dhit, 0);
    tick();
    chk("x_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
